// File: rtl/dds_pkg.sv
`timescale 1ns/1ps
// Shared types and default widths for the DDS pulse-gating path.
package dds_pkg;

    localparam int DDS_DATA_W = 32;
    localparam int DDS_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } gate_state_e;

endpackage

// File: rtl/dds_pri_timer.sv
`timescale 1ns/1ps
// PRI counter: free-runs 0..pri-1 while enabled; the wrap strobe marks a pulse start.
module dds_pri_timer
    import dds_pkg::*;
#(
    parameter int CNT_W = DDS_CNT_W
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] pri_i,
    input  logic             clear_i,
    input  logic             run_i,
    output logic             wrap_o
);

    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_end;

    assign at_end = (cnt_q == period_q - CNT_W'(1));
    assign wrap_o = run_i && at_end;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            period_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load_i) begin
                period_q <= pri_i;
            end
        end
    end

endmodule

// File: rtl/dds_pulse_gate.sv
`timescale 1ns/1ps
// Gates a free-running DDS sample stream into RADAR pulses, one AXI4-Stream packet
// per pulse; samples outside a pulse are drained so the DDS phase stays continuous.
module dds_pulse_gate
    import dds_pkg::*;
#(
    parameter int DATA_W = DDS_DATA_W,
    parameter int CNT_W  = DDS_CNT_W
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              enable_i,
    input  logic [CNT_W-1:0]  pulse_width_i,
    input  logic [CNT_W-1:0]  pri_i,
    input  logic [15:0]       num_pulses_i,
    input  logic [DATA_W-1:0] s_axis_data_tdata,
    input  logic              s_axis_data_tvalid,
    output logic              s_axis_data_tready,
    output logic [DATA_W-1:0] m_axis_pulse_tdata,
    output logic              m_axis_pulse_tvalid,
    output logic              m_axis_pulse_tlast,
    input  logic              m_axis_pulse_tready,
    output logic              busy_o,
    output logic              pulse_active_o,
    output logic [15:0]       pulse_count_o,
    output logic              frame_done_o,
    output logic              overrun_o,
    output logic              cfg_err_o
);

    gate_state_e       state_q;
    logic              en_q;
    logic [CNT_W-1:0]  pw_q;
    logic [CNT_W-1:0]  smp_cnt_q;
    logic [15:0]       np_q;
    logic [15:0]       pcnt_q;
    logic              ovr_q;
    logic              cfg_err_q;
    logic              wrap_pend_q;
    logic              m_valid_q;
    logic              m_last_q;
    logic [DATA_W-1:0] m_data_q;

    logic        start;
    logic        cfg_ok;
    logic        timer_run;
    logic        pri_wrap;
    logic        s_ready;
    logic        in_hs;
    logic        out_hs;
    logic        last_hs;
    logic        frame_end;
    logic [15:0] pcnt_inc;

    assign start     = (state_q == ST_IDLE) && enable_i && !en_q;
    assign cfg_ok    = (pulse_width_i != '0) && (pri_i > pulse_width_i);
    assign timer_run = (state_q == ST_ON) || (state_q == ST_OFF);
    assign s_ready   = (state_q == ST_OFF) ||
                       ((state_q == ST_ON) && (!m_valid_q || m_axis_pulse_tready) &&
                        (smp_cnt_q < pw_q));
    assign in_hs     = s_axis_data_tvalid && s_ready;
    assign out_hs    = m_valid_q && m_axis_pulse_tready;
    assign last_hs   = out_hs && m_last_q;
    assign pcnt_inc  = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;
    assign frame_end = (np_q != 16'd0) && (({1'b0, pcnt_q} + 17'd1) == {1'b0, np_q});

    dds_pri_timer #(
        .CNT_W (CNT_W)
    ) u_pri_timer (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .load_i   (start),
        .pri_i    (pri_i),
        .clear_i  (start),
        .run_i    (timer_run),
        .wrap_o   (pri_wrap)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            pw_q        <= '0;
            np_q        <= '0;
            smp_cnt_q   <= '0;
            pcnt_q      <= '0;
            ovr_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
            wrap_pend_q <= 1'b0;
        end else begin
            en_q <= enable_i;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pw_q        <= pulse_width_i;
                        np_q        <= num_pulses_i;
                        pcnt_q      <= '0;
                        ovr_q       <= 1'b0;
                        smp_cnt_q   <= '0;
                        wrap_pend_q <= 1'b0;
                        if (cfg_ok) begin
                            cfg_err_q <= 1'b0;
                            state_q   <= ST_ON;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    if (in_hs) begin
                        smp_cnt_q <= smp_cnt_q + CNT_W'(1);
                    end
                    // A wrap landing on the tlast handshake is an on-time start, not an overrun.
                    if (last_hs) begin
                        pcnt_q      <= pcnt_inc;
                        smp_cnt_q   <= '0;
                        wrap_pend_q <= 1'b0;
                        if (frame_end || !enable_i) begin
                            state_q <= ST_DONE;
                        end else if (wrap_pend_q || pri_wrap) begin
                            state_q <= ST_ON;
                        end else begin
                            state_q <= ST_OFF;
                        end
                    end else if (pri_wrap) begin
                        ovr_q       <= 1'b1;
                        wrap_pend_q <= 1'b1;
                    end
                end
                ST_OFF: begin
                    if (!enable_i) begin
                        state_q <= ST_DONE;
                    end else if (pri_wrap) begin
                        state_q <= ST_ON;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else if (in_hs && (state_q == ST_ON)) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_axis_data_tdata;
            m_last_q  <= (smp_cnt_q == pw_q - CNT_W'(1));
        end else if (out_hs) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end
    end

    assign s_axis_data_tready  = s_ready;
    assign m_axis_pulse_tdata  = m_data_q;
    assign m_axis_pulse_tvalid = m_valid_q;
    assign m_axis_pulse_tlast  = m_last_q;
    assign busy_o              = (state_q != ST_IDLE);
    assign pulse_active_o      = (state_q == ST_ON);
    assign pulse_count_o       = pcnt_q;
    assign frame_done_o        = (state_q == ST_DONE);
    assign overrun_o           = ovr_q;
    assign cfg_err_o           = cfg_err_q;

endmodule

// File: tb/tb_dds_pulse_gate.sv
`timescale 1ns/1ps
// Scoreboard bench for dds_pulse_gate: the DDS source is a per-cycle ramp, so the
// expected pulse contents follow directly from frame start time, PRI and width.
module tb_dds_pulse_gate;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              enable = 1'b0;
    logic [CNT_W-1:0]  pw_s = '0;
    logic [CNT_W-1:0]  pri_s = '0;
    logic [15:0]       np_s = '0;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid = 1'b1;
    logic              s_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic              busy;
    logic              pulse_active;
    logic [15:0]       pulse_count;
    logic              frame_done;
    logic              overrun;
    logic              cfg_err;

    dds_pulse_gate #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i               (clk),
        .resetn_i            (resetn),
        .enable_i            (enable),
        .pulse_width_i       (pw_s),
        .pri_i               (pri_s),
        .num_pulses_i        (np_s),
        .s_axis_data_tdata   (s_tdata),
        .s_axis_data_tvalid  (s_tvalid),
        .s_axis_data_tready  (s_tready),
        .m_axis_pulse_tdata  (m_tdata),
        .m_axis_pulse_tvalid (m_tvalid),
        .m_axis_pulse_tlast  (m_tlast),
        .m_axis_pulse_tready (m_tready),
        .busy_o              (busy),
        .pulse_active_o      (pulse_active),
        .pulse_count_o       (pulse_count),
        .frame_done_o        (frame_done),
        .overrun_o           (overrun),
        .cfg_err_o           (cfg_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign s_tdata = DATA_W'(cyc);

    int   rdy_mode = 0;
    logic rnd_rdy  = 1'b1;
    always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));
    assign m_tready = (rdy_mode == 0) ? 1'b1 : ((rdy_mode == 1) ? cyc[0] : rnd_rdy);

    typedef struct {
        bit          exact;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors = 0;
    int   fd_cnt = 0;
    int   off_cycles = 0;
    int   off_nrdy = 0;
    bit   seen_busy = 0;
    bit   sb_ignore = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each output handshake, watches hold-under-stall.
    initial begin : monitor
        exp_t        e;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [31:0] pkt_prev;
        bit          in_pkt;
        bit          ok;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        pkt_prev   = '0;
        in_pkt     = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_stall = 1'b0;
                in_pkt     = 0;
            end else begin
                if (frame_done) fd_cnt++;
                if (busy) seen_busy = 1;
                if (busy && !pulse_active && !frame_done) begin
                    off_cycles++;
                    if (!s_tready) off_nrdy++;
                end
                if (prev_stall) begin
                    vectors++;
                    if (!(m_tvalid && m_tdata == prev_data && m_tlast == prev_last)) begin
                        errors++;
                        $display("FAIL hold: got v=%0b d=%0h l=%0b, expected v=1 d=%0h l=%0b",
                                 m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
                    end
                end
                if (m_tvalid && m_tready && !sb_ignore) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out: got d=%0h l=%0b, expected no output",
                                 m_tdata, m_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.exact) ok = (m_tdata == e.data) && (m_tlast == e.last);
                        else ok = (m_tlast == e.last) && (!in_pkt || m_tdata > pkt_prev);
                        if (!ok) begin
                            errors++;
                            $display("FAIL sample: got d=%0h l=%0b, expected d=%0h l=%0b (exact=%0b)",
                                     m_tdata, m_tlast, e.data, e.last, e.exact);
                        end
                    end
                    pkt_prev = m_tdata;
                    in_pkt   = !m_tlast;
                end
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_tlast"}, 32'(m_tlast), 32'd0);
        check({tag, "_tdata"}, m_tdata, 32'd0);
        check({tag, "_s_tready"}, 32'(s_tready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pulse_active"}, 32'(pulse_active), 32'd0);
        check({tag, "_pulse_count"}, 32'(pulse_count), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    endtask

    // One frame: with enable dropped d cycles after arming, pulse k still starts iff k*pri < d.
    task automatic run_frame(input int pw, input int pri, input int np, input int d,
                             input bit exact, input bit exp_ovr);
        int unsigned n0;
        int          k_tot;
        int          limit;
        bit          finished;
        exp_t        e;
        enable = 1'b0;
        tick(2);
        fd_cnt     = 0;
        off_cycles = 0;
        off_nrdy   = 0;
        pw_s  = CNT_W'(pw);
        pri_s = CNT_W'(pri);
        np_s  = 16'(np);
        enable = 1'b1;
        n0 = cyc;
        k_tot = (d == 0) ? np : (d + pri - 1) / pri;
        if (np != 0 && np < k_tot) k_tot = np;
        for (int k = 0; k < k_tot; k++) begin
            for (int i = 0; i < pw; i++) begin
                e.exact = exact;
                e.data  = n0 + 1 + k * pri + i;
                e.last  = (i == pw - 1);
                exp_q.push_back(e);
            end
        end
        limit = (pri + 4 * pw + 8) * (k_tot + 1) * 3 + 50;
        finished = 0;
        for (int c = 1; c <= limit; c++) begin
            tick(1);
            if (c == d) enable = 1'b0;
            if (c == 2) begin
                pw_s  = CNT_W'($urandom_range(0, 3));
                pri_s = CNT_W'($urandom_range(0, 3));
                np_s  = 16'($urandom_range(1, 9));
            end
            if (c > 1 && !busy) begin
                finished = 1;
                break;
            end
        end
        if (!finished) begin
            vectors++;
            errors++;
            $display("FAIL frame_timeout: got busy=%0b after %0d cycles, expected idle", busy, limit);
        end
        enable = 1'b0;
        tick(2);
        check("leftover_samples", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check("frame_done_count", 32'(fd_cnt), 32'd1);
        check("pulse_count", 32'(pulse_count), 32'(k_tot));
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
        check("off_s_tready", 32'(off_nrdy), 32'd0);
        if (exact) check("overrun_clear", 32'(overrun), 32'd0);
        if (exp_ovr) begin
            check("overrun_set", 32'(overrun), 32'd1);
            check("no_off_after_overrun", 32'(off_cycles), 32'd0);
        end
    endtask

    task automatic run_cfg_err(input int pw, input int pri);
        enable = 1'b0;
        tick(2);
        pw_s  = CNT_W'(pw);
        pri_s = CNT_W'(pri);
        np_s  = 16'd2;
        seen_busy = 0;
        enable = 1'b1;
        tick(8);
        check("cfg_err_set", 32'(cfg_err), 32'd1);
        check("cfg_err_busy", 32'(seen_busy), 32'd0);
        check("cfg_err_no_data", 32'(exp_q.size()), 32'd0);
        enable = 1'b0;
        tick(1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int pw;
        int pri;
        int np;
        int mode;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick(2);

        run_frame(4, 10, 3, 0, 1, 0);
        run_frame(3, 7, 2, 0, 1, 0);
        run_cfg_err(0, 10);
        run_cfg_err(4, 4);
        run_frame(5, 6, 2, 0, 1, 0);

        rdy_mode = 1;
        run_frame(8, 12, 3, 0, 0, 1);
        rdy_mode = 0;

        run_frame(6, 10, 0, 3, 1, 0);
        run_frame(3, 10, 0, 15, 1, 0);

        for (int t = 0; t < 8; t++) begin
            pw   = int'($urandom_range(1, 6));
            pri  = int'($urandom_range(pw + 1, pw + 8));
            np   = int'($urandom_range(1, 3));
            mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            rdy_mode = mode;
            run_frame(pw, pri, np, 0, mode == 0, 0);
            rdy_mode = 0;
        end

        enable = 1'b0;
        tick(2);
        pw_s  = CNT_W'(6);
        pri_s = CNT_W'(10);
        np_s  = 16'd2;
        sb_ignore = 1;
        enable = 1'b1;
        tick(3);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        enable = 1'b0;
        resetn = 1'b1;
        tick(2);
        exp_q.delete();
        sb_ignore = 0;
        run_frame(4, 9, 2, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
